muldiv: RTL

MULDIV -- requirements
Module: muldiv

---
 rtl/cpu_types_pkg.sv | 28 ++
 rtl/muldiv_if.sv | 30 +++
 rtl/muldiv.sv | 127 ++++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// Shared types for the iterative multiply/divide unit: operation codes,
// FSM states and small decode helpers.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    MULT  = 2'b00,
    MULTU = 2'b01,
    DIV   = 2'b10,
    DIVU  = 2'b11
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } muldiv_state_t;

  localparam int unsigned ITER_CNT_W = 6;

  function automatic logic op_is_div(input muldiv_op_t op);
    return (op == DIV) || (op == DIVU);
  endfunction

  function automatic logic op_is_signed(input muldiv_op_t op);
    return (op == MULT) || (op == DIV);
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Signal bundle for the multiply/divide unit; mdu is the block's view,
// tb the requester's view.
interface muldiv_if
  import cpu_types_pkg::*;
#(
  parameter int WORD_W = 32
) (
  input logic CLK
);
  logic              nRST;
  logic              start;
  muldiv_op_t        op;
  logic [WORD_W-1:0] port_a;
  logic [WORD_W-1:0] port_b;
  logic              busy;
  logic              done;
  logic [WORD_W-1:0] hi;
  logic [WORD_W-1:0] lo;
  logic              div_by_zero;

  modport mdu (
    input  CLK, nRST, start, op, port_a, port_b,
    output busy, done, hi, lo, div_by_zero
  );

  modport tb (
    input  CLK, busy, done, hi, lo, div_by_zero,
    output nRST, start, op, port_a, port_b
  );
endinterface

// File: rtl/muldiv.sv
// Iterative radix-2 multiplier/divider: shift-add multiply, restoring divide,
// one step per cycle on magnitudes with sign fix-up on the last step.
module muldiv
  import cpu_types_pkg::*;
#(
  parameter int WORD_W = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              start,
  input  muldiv_op_t        op,
  input  logic [WORD_W-1:0] port_a,
  input  logic [WORD_W-1:0] port_b,
  output logic              busy,
  output logic              done,
  output logic [WORD_W-1:0] hi,
  output logic [WORD_W-1:0] lo,
  output logic              div_by_zero
);

  localparam int ACC_W = 2 * WORD_W;
  localparam logic [ITER_CNT_W-1:0] LAST_ITER = ITER_CNT_W'(WORD_W - 1);

  muldiv_state_t           state_q, state_d;
  muldiv_op_t              op_q;
  logic [ACC_W-1:0]        acc_q;
  logic [WORD_W-1:0]       opb_q;
  logic                    sign_a_q, sign_b_q;
  logic [ITER_CNT_W-1:0]   cnt_q;
  logic [WORD_W-1:0]       hi_q, lo_q;
  logic                    dbz_q;

  logic                    start_dbz;
  logic [WORD_W-1:0]       mag_a, mag_b;
  logic [WORD_W:0]         mul_sum, rem_shift, rem_diff;
  logic [ACC_W-1:0]        step_acc, fin_acc;

  always_comb begin
    start_dbz = op_is_div(op) && (port_b == '0);
    mag_a = (op_is_signed(op) && port_a[WORD_W-1]) ? -port_a : port_a;
    mag_b = (op_is_signed(op) && port_b[WORD_W-1]) ? -port_b : port_b;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = start_dbz ? DONE : RUN;
      RUN:     if (cnt_q == LAST_ITER) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Accumulator holds {partial product, multiplier} or {remainder, dividend/quotient}.
  always_comb begin
    mul_sum   = {1'b0, acc_q[ACC_W-1:WORD_W]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    rem_shift = {acc_q[ACC_W-1:WORD_W], acc_q[WORD_W-1]};
    rem_diff  = rem_shift - {1'b0, opb_q};
    if (op_is_div(op_q)) begin
      if (rem_diff[WORD_W]) step_acc = {rem_shift[WORD_W-1:0], acc_q[WORD_W-2:0], 1'b0};
      else                  step_acc = {rem_diff[WORD_W-1:0], acc_q[WORD_W-2:0], 1'b1};
    end else begin
      step_acc = {mul_sum, acc_q[WORD_W-1:1]};
    end

    fin_acc = step_acc;
    if (op_is_signed(op_q)) begin
      if (op_is_div(op_q)) begin
        if (sign_a_q ^ sign_b_q) fin_acc[WORD_W-1:0] = -step_acc[WORD_W-1:0];
        if (sign_a_q)            fin_acc[ACC_W-1:WORD_W] = -step_acc[ACC_W-1:WORD_W];
      end else if (sign_a_q ^ sign_b_q) begin
        fin_acc = -step_acc;
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= IDLE;
      op_q     <= MULT;
      acc_q    <= '0;
      opb_q    <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      dbz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (start) begin
            op_q     <= op;
            sign_a_q <= op_is_signed(op) & port_a[WORD_W-1];
            sign_b_q <= op_is_signed(op) & port_b[WORD_W-1];
            opb_q    <= mag_b;
            acc_q    <= {{WORD_W{1'b0}}, mag_a};
            cnt_q    <= '0;
            if (start_dbz) begin
              hi_q  <= port_a;
              lo_q  <= '1;
              dbz_q <= 1'b1;
            end
          end
        end
        RUN: begin
          acc_q <= step_acc;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST_ITER) begin
            hi_q  <= fin_acc[ACC_W-1:WORD_W];
            lo_q  <= fin_acc[WORD_W-1:0];
            dbz_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_by_zero = dbz_q;

endmodule
